mole_ctrl: RTL and testbench

MOLE_CTRL -- requirements
Module: mole_ctrl

---
 rtl/mole_pkg.sv | 23 ++
 rtl/mole_lfsr.sv | 19 +
 rtl/mole_ctrl.sv | 132 +++++++++++++
 tb/tb_mole_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and default constants for the whack-a-mole controller.
package mole_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_SHOW,
    S_GAP,
    S_OVER
  } state_t;

  localparam int GAME_SEC_DEF      = 30;
  localparam int TICKS_PER_SEC_DEF = 8;
  localparam int WIN_TICKS_DEF     = 8;
  localparam int GAP_TICKS_DEF     = 2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepping every clock.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] rnd
);

  logic [7:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= LFSR_SEED;
    else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

  assign rnd = q[1:0];

endmodule

// File: rtl/mole_ctrl.sv
// Whack-a-mole controller: mole spawning, hit scoring and game timer.
// Define MOLE_CTRL_SPEEDUP_EN to halve the mole window late in a game.
module mole_ctrl
  import mole_pkg::*;
#(
  parameter int GAME_SEC      = GAME_SEC_DEF,
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int WIN_TICKS     = WIN_TICKS_DEF,
  parameter int GAP_TICKS     = GAP_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] mole_pos,
  output logic       getpoint,
  output logic [1:0] p,
  output logic       new_game,
  output logic [5:0] time_left,
  output logic       game_over
);

  localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  state_t        state, state_n;
  logic          start_q;
  logic [3:0]    btn_q;
  logic [SW-1:0] sec_cnt;
  logic [3:0]    win, thr, gap_cnt, win_load;
  logic [1:0]    pos, rnd, pos_new;
  logic [3:0]    btn_e;
  logic          start_e, in_play, sec_end, expire, hit, launch;

  mole_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  assign start_e = start & ~start_q;
  assign btn_e   = btn & ~btn_q;
  assign in_play = state inside {S_SPAWN, S_SHOW, S_GAP};
  assign launch  = (state inside {S_IDLE, S_OVER}) && start_e;
  assign sec_end = in_play && tick
                && (sec_cnt == SW'(TICKS_PER_SEC - 1));
  assign expire  = sec_end && (time_left == 6'd1);

  assign mole_pos  = (state == S_SHOW) ? onehot(pos) : 4'd0;
  assign game_over = (state == S_OVER);
  assign hit       = (state == S_SHOW) && (btn_e == mole_pos);

  // never light the same hole twice in a row
  assign pos_new = (rnd == pos) ? rnd + 2'd1 : rnd;

`ifdef MOLE_CTRL_SPEEDUP_EN
  assign win_load = (time_left > 6'(GAME_SEC / 2))
                  ? 4'(WIN_TICKS) : 4'(WIN_TICKS / 2);
`else
  assign win_load = 4'(WIN_TICKS);
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE,
      S_OVER:  if (start_e) state_n = S_SPAWN;
      S_SPAWN: state_n = S_SHOW;
      S_SHOW: begin
        if (hit)                      state_n = S_GAP;
        else if (tick && win == 4'd1) state_n = S_GAP;
      end
      S_GAP: begin
        if (tick && gap_cnt == 4'(GAP_TICKS - 1))
          state_n = S_SPAWN;
      end
      default: state_n = S_IDLE;
    endcase
    // time expiry overrides any play transition
    if (expire) state_n = S_OVER;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      btn_q     <= 4'd0;
      getpoint  <= 1'b0;
      p         <= 2'd0;
      new_game  <= 1'b0;
      time_left <= 6'd0;
      sec_cnt   <= '0;
      win       <= 4'd0;
      thr       <= 4'd0;
      gap_cnt   <= 4'd0;
      pos       <= 2'd0;
    end else begin
      state    <= state_n;
      start_q  <= start;
      btn_q    <= btn;
      new_game <= launch;
      getpoint <= hit;
      p        <= hit ? ((win > thr) ? 2'd2 : 2'd1) : 2'd0;

      if (launch) begin
        time_left <= 6'(GAME_SEC);
        sec_cnt   <= '0;
      end else if (in_play && tick) begin
        if (sec_end) begin
          sec_cnt   <= '0;
          time_left <= time_left - 6'd1;
        end else begin
          sec_cnt <= sec_cnt + SW'(1);
        end
      end

      if (state == S_SPAWN) begin
        pos <= pos_new;
        win <= win_load;
        thr <= win_load >> 1;
      end else if (state == S_SHOW && !hit && tick) begin
        win <= win - 4'd1;
      end

      if (state == S_SHOW)
        gap_cnt <= 4'd0;
      else if (state == S_GAP && tick)
        gap_cnt <= gap_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mole_ctrl.sv
// Bench for mole_ctrl: game-level reference model plus directed and random play.
module tb_mole_ctrl;

  localparam int GS  = 30;
  localparam int TPS = 8;
  localparam int WT  = 8;
  localparam int GT  = 2;

  logic       clk = 0, rst = 0, tick = 0, start = 0;
  logic [3:0] btn = 0;
  logic [3:0] mole_pos;
  logic       getpoint, new_game, game_over;
  logic [1:0] p;
  logic [5:0] time_left;

  mole_ctrl #(
    .GAME_SEC(GS), .TICKS_PER_SEC(TPS),
    .WIN_TICKS(WT), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .start(start), .btn(btn),
    .mole_pos(mole_pos), .getpoint(getpoint),
    .p(p), .new_game(new_game),
    .time_left(time_left), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // game-level model: lit = hole index or -1
  logic [7:0] m_lfsr;
  bit         m_sq, m_play, m_over, m_spawn, m_gap;
  bit   [3:0] m_bq;
  int         m_lit, m_win, m_thr, m_gcnt, m_sub, m_time, m_prev;
  bit         m_gp, m_ng;
  int         m_p;
  bit         chk_en = 0, last_gp = 0;
  int         gp_seen = 0;

  task automatic model_step();
    bit se, expire;
    bit [3:0] be;
    int load, ps;
    se = start && !m_sq;
    be = btn & ~m_bq;
    m_gp = 0; m_p = 0; m_ng = 0;
    load = WT;
`ifdef MOLE_CTRL_SPEEDUP_EN
    if (m_time <= GS / 2) load = WT / 2;
`endif
    if (!m_play) begin
      if (se) begin
        m_play = 1; m_over = 0; m_time = GS; m_sub = 0;
        m_spawn = 1; m_gap = 0; m_lit = -1; m_ng = 1;
      end
    end else begin
      expire = tick && m_sub == TPS - 1 && m_time == 1;
      if (m_spawn) begin
        ps = int'(m_lfsr[1:0]);
        if (ps == m_prev) ps = (ps + 1) % 4;
        m_prev = ps; m_lit = ps;
        m_win = load; m_thr = load / 2; m_spawn = 0;
      end else if (m_lit >= 0) begin
        if (be == 4'(1 << m_lit)) begin
          m_gp = 1; m_p = (m_win > m_thr) ? 2 : 1;
          m_lit = -1; m_gap = 1; m_gcnt = 0;
        end else if (tick) begin
          m_win--;
          if (m_win == 0) begin
            m_lit = -1; m_gap = 1; m_gcnt = 0;
          end
        end
      end else if (m_gap && tick) begin
        m_gcnt++;
        if (m_gcnt == GT) begin m_gap = 0; m_spawn = 1; end
      end
      if (tick) begin
        if (m_sub == TPS - 1) begin m_sub = 0; m_time--; end
        else m_sub++;
      end
      if (expire) begin
        m_play = 0; m_over = 1; m_lit = -1;
        m_spawn = 0; m_gap = 0;
      end
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_sq = start;
    m_bq = btn;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = 8'hA5; m_sq = 0; m_bq = 0;
      m_play = 0; m_over = 0; m_spawn = 0; m_gap = 0;
      m_lit = -1; m_win = 0; m_thr = 0; m_gcnt = 0;
      m_sub = 0; m_time = 0; m_prev = 0;
      m_gp = 0; m_ng = 0; m_p = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] ep;
      ep = (m_lit >= 0) ? 4'(1 << m_lit) : 4'd0;
      tests++;
      if (mole_pos !== ep || getpoint !== m_gp || p !== m_p[1:0]
          || new_game !== m_ng || time_left !== m_time[5:0]
          || game_over !== m_over) begin
        fails++;
        $display("FAIL model t=%0t pos=%h/%h gp=%b/%b p=%0d/%0d ng=%b/%b tl=%0d/%0d go=%b/%b",
                 $time, mole_pos, ep, getpoint, m_gp, p, m_p, new_game, m_ng,
                 time_left, m_time, game_over, m_over);
      end
      tests++;
      if (getpoint === 1'b1 && last_gp) begin
        fails++;
        $display("FAIL gp_consecutive t=%0t actual=1 required=0", $time);
      end
      last_gp = (getpoint === 1'b1);
      if (getpoint === 1'b1) gp_seen++;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_tick();
    tick = 1; cyc(); tick = 0;
  endtask

  task automatic tick_idle();
    do_tick(); cyc();
  endtask

  task automatic wait_lit();
    int n = 0;
    while (m_lit < 0 && n < 200) begin
      if (m_gap) do_tick(); else cyc();
      n++;
    end
    chk("wait_lit", 32'(m_lit >= 0), 1);
  endtask

  task automatic press();
    btn = 4'(1 << m_lit); cyc(); btn = 0;
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int g0, r, rr;
    bit done;
    #1 rst = 1;
    repeat (3) cyc();
    chk_en = 1;
    chk("rst_mole", 32'(mole_pos), 0);
    chk("rst_time", 32'(time_left), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_gp", 32'(getpoint), 0);
    #2 rst = 0;
    cyc();

    start = 1; cyc();
    chk("new_game", 32'(new_game), 1);
    chk("time_init", 32'(time_left), 30);
    cyc();
    chk("onehot", 32'($onehot(mole_pos)), 1);
    chk("ng_pulse", 32'(new_game), 0);

    do_tick(); press();
    chk("hit1_gp", 32'(getpoint), 1);
    chk("hit1_p", 32'(p), 2);
    chk("hit1_mole", 32'(mole_pos), 0);
    cyc();
    chk("hit1_gp_drop", 32'(getpoint), 0);

    wait_lit();
    repeat (6) tick_idle();
    press();
    chk("hit6_gp", 32'(getpoint), 1);
    chk("hit6_p", 32'(p), 1);

    wait_lit();
    g0 = gp_seen;
    repeat (8) tick_idle();
    chk("miss_gap", 32'(mole_pos), 0);
    chk("miss_nogp", 32'(gp_seen - g0), 0);

    wait_lit();
    btn = 4'hF; cyc(); btn = 0;
    chk("all4_nogp", 32'(getpoint), 0);
    cyc();
    chk("all4_still_lit", 32'(mole_pos != 0), 1);

    g0 = gp_seen;
    btn = 4'(1 << m_lit);
    repeat (6) cyc();
    btn = 0; cyc();
    chk("hold_once", 32'(gp_seen - g0), 1);

    start = 0; cyc(); start = 1; cyc();
    chk("start_ignored", 32'(new_game), 0);

    start = 0;
    #2 rst = 1; cyc();
    #2 rst = 0; cyc();
    start = 1; cyc();
    chk("g2_new_game", 32'(new_game), 1);
    repeat (239) tick_idle();
    chk("pre_exp_over", 32'(game_over), 0);
    chk("pre_exp_time", 32'(time_left), 1);
    do_tick();
    chk("exp_time", 32'(time_left), 0);
    chk("exp_over", 32'(game_over), 1);
    chk("exp_mole", 32'(mole_pos), 0);

    start = 0; cyc(); start = 1; cyc();
    chk("g3_new_game", 32'(new_game), 1);
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      rr = TPS * (m_time - 1) + (TPS - m_sub);
      if (m_lit >= 0) begin
        if (rr == 1) begin
          btn = 4'(1 << m_lit); tick = 1;
          cyc();
          btn = 0; tick = 0;
          done = 1;
        end else if (rr % 2 == 1) begin
          press();
        end else begin
          do_tick();
        end
      end else if (m_gap) begin
        do_tick();
      end else begin
        cyc();
      end
    end
    chk("exphit_reached", 32'(done), 1);
    chk("exphit_gp", 32'(getpoint), 1);
    chk("exphit_over", 32'(game_over), 1);
    chk("exphit_time", 32'(time_left), 0);
    cyc();
    chk("exphit_gp_drop", 32'(getpoint), 0);

    start = 0;
    for (int i = 0; i < 15000; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 99);
      if (m_lit >= 0 && r < 4) btn = 4'(1 << m_lit);
      else if (r < 6)          btn = 4'hF;
      else if (r < 10)         btn = 4'($urandom);
      else if (r >= 70)        btn = 4'd0;
      if ($urandom_range(0, 49) == 0) start = ~start;
      if ($urandom_range(0, 2999) == 0) begin
        #2 rst = 1; cyc();
        #2 rst = 0;
      end
      cyc();
    end
    tick = 0; btn = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
